spec_tracker_mw: RTL and testbench
==================================

# spec_tracker_mw

Multi-port successor to the single-writeback speculation tracker. Holds up to SPEC_DEPTH unresolved predicted branches in age order. Resolves them against NUM_WB condition-register writebacks per cycle, reports the oldest misprediction with its rollback state, and compacts surviving entries. A new branch whose condition resolves in the same cycle it is pushed is resolved by bypass instead of being stored. Sits between issue/rename (branch push) and the register file / tag logic (spec level tracking, rollback).

## Interface
- NUM_TAG, 4, rename tags per rollback map
- NUM_REG, 8, architectural registers; REG_ID_BIT = clog2(NUM_REG)
- SPEC_DEPTH, 4, max outstanding branches; LVL_BIT = clog2(SPEC_DEPTH)+1
- NUM_WB, 2, condition writeback ports per cycle
- PC_BIT, 4, rollback PC width
- INST_ID_BIT, 8, rollback instruction-id width
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all entries (exception/external redirect)
- br_vld  in  1  branch push request
- br_rdy  out  1  space available: registered count < SPEC_DEPTH
- br_cond_reg  in  REG_ID_BIT  predicted condition register
- br_cond_pred  in  1  predicted value
- br_fail_pc / br_fail_id / br_fail_tag_map  in  PC_BIT / INST_ID_BIT / NUM_TAG*REG_ID_BIT  rollback state
- wb_vld  in  NUM_WB  per-port condition writeback valid
- wb_reg  in  NUM_WB*REG_ID_BIT  written register, port p at [p*REG_ID_BIT +: REG_ID_BIT]
- wb_val  in  NUM_WB  written condition value
- cur_spec_level  out  LVL_BIT  level of instructions executing this cycle (count after this cycle's resolutions)
- succ_vld  out  1  at least one entry resolved correctly this cycle
- nxt_levels  out  LVL_BIT*(SPEC_DEPTH+1)  new level for each old level 0..SPEC_DEPTH; level 0 maps to 0
- fail_vld  out  1  misprediction this cycle
- fail_level  out  LVL_BIT  levels >= this are squashed
- fail_pc / fail_id / fail_tag_map  out  rollback state of the failing entry
- spec_cnt  out  LVL_BIT  registered entry count

## Operation
- Entries occupy indices 0..cnt-1, oldest at 0. Index i is level i+1.
- Match: entry i matches port p when the entry is valid, wb_vld[p] is high, and reg equal. If several ports carry the same reg, the lowest p wins.
- Matched entry outcome: success when the winning wb_val equals pred, else mispredict.
- fail index F is the lowest mispredicted index.
  - fail_vld=1, fail_level=F+1, fail outputs take entry F's state.
  - Next state: compaction of the unmatched entries with index < F. Push is ignored.
- No fail: next state is compaction of all unmatched entries, order preserved.
  - If br_vld&&br_rdy, the push is appended after them.
- nxt_levels[k] = 1 + number of unmatched valid entries below index k-1, for surviving levels. It is don't-care for resolved or squashed levels.
- Bypass: if br_vld&&br_rdy and br_cond_reg matches a wb port, the push is not stored.
  - Bypass mispredict with no stored fail: fail_vld=1, fail_level = surviving count+1, fail outputs take the br_* state.
  - A stored fail has priority over a bypass fail.
- flush: all entries invalid next cycle. fail_vld/succ_vld are forced 0 and push is ignored. Higher priority than everything except rst.
- cur_spec_level = number of surviving entries this cycle. It excludes a same-cycle push and any squashed entries.
- rst: entries invalid, spec_cnt=0. With inputs idle: br_rdy=1, cur_spec_level=0, fail_vld=0, succ_vld=0, fail_level=0, nxt_levels all identity.

## Timing
- Resolution outputs are combinational from wb_* and registered state, valid in the same cycle.
- Entry array and spec_cnt update on the next rising clk.
- br_rdy is based on the registered count only. It does not see same-cycle frees, so a full tracker stalls one cycle even if an entry resolves.
- Boundaries:
  - full + success: no push that cycle; br_rdy=1 next cycle.
  - all entries resolve correctly together: cnt 0.
  - fail at index 0 with push: push dropped, cnt 0.
  - rst mid-operation: state cleared on that edge regardless of other inputs.

## Test plan
- Reset, then push r3/pred1 and r5/pred0 -> spec_cnt=2, cur_spec_level=2, br_rdy=1.
- With entries r3,r5,r6 (preds 1,0,1): wb0=r5 val0 -> succ_vld=1, nxt_levels[3]=2; next cycle cnt=2 with order r3,r6.
- Same three entries: wb0=r5 val1 and wb1=r6 val0 -> fail_vld=1, fail_level=2, entry1 rollback state is output; next cnt=1.
- Full (4 entries): wb resolves entry0 correctly while br_vld=1 -> br_rdy=0, push rejected; next cycle cnt=3, br_rdy=1.
- cnt=1: push r2/pred1 while wb0=r2 val0 -> bypass fail, fail_level=2, fail_pc=br_fail_pc; next cnt=1.
- cnt=3 with flush and wb mispredict in the same cycle -> fail_vld=0; next cnt=0, cur_spec_level=0.

Source files
------------

// File: rtl/spec_tracker_mw_if.sv
// Branch push, condition writeback and resolution/rollback bundle for spec_tracker_mw.
// The master drives pushes and writebacks. The slave is the tracker.
interface spec_tracker_mw_if #(
  parameter int NUM_TAG     = 4,
  parameter int NUM_REG     = 8,
  parameter int SPEC_DEPTH  = 4,
  parameter int NUM_WB      = 2,
  parameter int PC_BIT      = 4,
  parameter int INST_ID_BIT = 8
);
  localparam int REG_ID_BIT = $clog2(NUM_REG);
  localparam int LVL_BIT    = $clog2(SPEC_DEPTH) + 1;
  localparam int TAG_BIT    = NUM_TAG * REG_ID_BIT;

  logic                              flush;
  logic                              br_vld;
  logic                              br_rdy;
  logic [REG_ID_BIT-1:0]             br_cond_reg;
  logic                              br_cond_pred;
  logic [PC_BIT-1:0]                 br_fail_pc;
  logic [INST_ID_BIT-1:0]            br_fail_id;
  logic [TAG_BIT-1:0]                br_fail_tag_map;
  logic [NUM_WB-1:0]                 wb_vld;
  logic [NUM_WB*REG_ID_BIT-1:0]      wb_reg;
  logic [NUM_WB-1:0]                 wb_val;
  logic [LVL_BIT-1:0]                cur_spec_level;
  logic                              succ_vld;
  logic [LVL_BIT*(SPEC_DEPTH+1)-1:0] nxt_levels;
  logic                              fail_vld;
  logic [LVL_BIT-1:0]                fail_level;
  logic [PC_BIT-1:0]                 fail_pc;
  logic [INST_ID_BIT-1:0]            fail_id;
  logic [TAG_BIT-1:0]                fail_tag_map;
  logic [LVL_BIT-1:0]                spec_cnt;

  modport master (
    output flush, br_vld, br_cond_reg, br_cond_pred, br_fail_pc, br_fail_id, br_fail_tag_map,
           wb_vld, wb_reg, wb_val,
    input  br_rdy, cur_spec_level, succ_vld, nxt_levels, fail_vld, fail_level,
           fail_pc, fail_id, fail_tag_map, spec_cnt
  );

  modport slave (
    input  flush, br_vld, br_cond_reg, br_cond_pred, br_fail_pc, br_fail_id, br_fail_tag_map,
           wb_vld, wb_reg, wb_val,
    output br_rdy, cur_spec_level, succ_vld, nxt_levels, fail_vld, fail_level,
           fail_pc, fail_id, fail_tag_map, spec_cnt
  );
endinterface

// File: rtl/spec_tracker_mw.sv
// Multi-writeback speculation tracker: resolves age-ordered predicted branches,
// reports the oldest misprediction with its rollback state, and compacts survivors.
module spec_tracker_mw #(
  parameter int NUM_TAG     = 4,
  parameter int NUM_REG     = 8,
  parameter int SPEC_DEPTH  = 4,
  parameter int NUM_WB      = 2,
  parameter int PC_BIT      = 4,
  parameter int INST_ID_BIT = 8
) (
  input  logic               clk,
  input  logic               rst,
  spec_tracker_mw_if.slave   bus
);
  localparam int REG_ID_BIT = $clog2(NUM_REG);
  localparam int LVL_BIT    = $clog2(SPEC_DEPTH) + 1;
  localparam int TAG_BIT    = NUM_TAG * REG_ID_BIT;

  logic [REG_ID_BIT-1:0]  ent_reg  [SPEC_DEPTH];
  logic                   ent_pred [SPEC_DEPTH];
  logic [PC_BIT-1:0]      ent_pc   [SPEC_DEPTH];
  logic [INST_ID_BIT-1:0] ent_id   [SPEC_DEPTH];
  logic [TAG_BIT-1:0]     ent_tag  [SPEC_DEPTH];
  logic [LVL_BIT-1:0]     cnt;

  logic [REG_ID_BIT-1:0]  nxt_reg  [SPEC_DEPTH];
  logic                   nxt_pred [SPEC_DEPTH];
  logic [PC_BIT-1:0]      nxt_pc   [SPEC_DEPTH];
  logic [INST_ID_BIT-1:0] nxt_id   [SPEC_DEPTH];
  logic [TAG_BIT-1:0]     nxt_tag  [SPEC_DEPTH];
  logic [LVL_BIT-1:0]     nxt_cnt;

  logic [SPEC_DEPTH-1:0]  valid, hit, hit_val, surv;
  logic [LVL_BIT-1:0]     rank [SPEC_DEPTH];
  logic [LVL_BIT-1:0]     surv_cnt, fidx, macc;
  logic                   found, any_ok, bp_hit, bp_val, bp_fail, push_acc, push_store, br_rdy_i;
  logic [PC_BIT-1:0]      f_pc;
  logic [INST_ID_BIT-1:0] f_id;
  logic [TAG_BIT-1:0]     f_tag;
  logic [LVL_BIT*(SPEC_DEPTH+1)-1:0] nl;

  // Writeback match: descending scan so the lowest matching port wins.
  always_comb begin
    for (int i = 0; i < SPEC_DEPTH; i++) begin
      valid[i]   = (LVL_BIT'(i) < cnt);
      hit[i]     = 1'b0;
      hit_val[i] = 1'b0;
      for (int p = NUM_WB - 1; p >= 0; p--) begin
        if (bus.wb_vld[p] && (bus.wb_reg[p*REG_ID_BIT +: REG_ID_BIT] == ent_reg[i])) begin
          hit[i]     = valid[i];
          hit_val[i] = bus.wb_val[p];
        end
      end
    end
    bp_hit = 1'b0;
    bp_val = 1'b0;
    for (int p = NUM_WB - 1; p >= 0; p--) begin
      if (bus.wb_vld[p] && (bus.wb_reg[p*REG_ID_BIT +: REG_ID_BIT] == bus.br_cond_reg)) begin
        bp_hit = 1'b1;
        bp_val = bus.wb_val[p];
      end
    end
  end

  always_comb begin
    found  = 1'b0;
    any_ok = 1'b0;
    fidx   = '0;
    f_pc   = '0;
    f_id   = '0;
    f_tag  = '0;
    for (int i = 0; i < SPEC_DEPTH; i++) begin
      if (hit[i] && (hit_val[i] == ent_pred[i])) any_ok = 1'b1;
      if (hit[i] && (hit_val[i] != ent_pred[i]) && !found) begin
        found = 1'b1;
        fidx  = LVL_BIT'(i);
        f_pc  = ent_pc[i];
        f_id  = ent_id[i];
        f_tag = ent_tag[i];
      end
    end
    surv_cnt = '0;
    for (int i = 0; i < SPEC_DEPTH; i++) begin
      surv[i]  = valid[i] && !hit[i] && (!found || (LVL_BIT'(i) < fidx));
      rank[i]  = surv_cnt;
      surv_cnt = surv_cnt + {{(LVL_BIT-1){1'b0}}, surv[i]};
    end
    // A level drops by the number of resolved entries older than it.
    nl   = '0;
    macc = '0;
    for (int k = 1; k <= SPEC_DEPTH; k++) begin
      nl[k*LVL_BIT +: LVL_BIT] = LVL_BIT'(k) - macc;
      macc = macc + {{(LVL_BIT-1){1'b0}}, hit[k-1]};
    end
  end

  assign br_rdy_i   = (cnt < LVL_BIT'(SPEC_DEPTH));
  assign push_acc   = bus.br_vld && br_rdy_i;
  assign bp_fail    = push_acc && bp_hit && (bp_val != bus.br_cond_pred);
  assign push_store = push_acc && !found && !bp_hit && !bus.flush;

  assign bus.br_rdy         = br_rdy_i;
  assign bus.spec_cnt       = cnt;
  assign bus.cur_spec_level = surv_cnt;
  assign bus.nxt_levels     = nl;
  assign bus.succ_vld       = any_ok && !bus.flush;
  assign bus.fail_vld       = !bus.flush && (found || bp_fail);
  assign bus.fail_level     = !bus.fail_vld ? '0 : (found ? fidx + 1'b1 : surv_cnt + 1'b1);
  assign bus.fail_pc        = found ? f_pc  : bus.br_fail_pc;
  assign bus.fail_id        = found ? f_id  : bus.br_fail_id;
  assign bus.fail_tag_map   = found ? f_tag : bus.br_fail_tag_map;

  // Compaction: each survivor moves to its rank, a stored push lands after them.
  always_comb begin
    for (int j = 0; j < SPEC_DEPTH; j++) begin
      nxt_reg[j]  = ent_reg[j];
      nxt_pred[j] = ent_pred[j];
      nxt_pc[j]   = ent_pc[j];
      nxt_id[j]   = ent_id[j];
      nxt_tag[j]  = ent_tag[j];
      for (int i = 0; i < SPEC_DEPTH; i++) begin
        if (surv[i] && (rank[i] == LVL_BIT'(j))) begin
          nxt_reg[j]  = ent_reg[i];
          nxt_pred[j] = ent_pred[i];
          nxt_pc[j]   = ent_pc[i];
          nxt_id[j]   = ent_id[i];
          nxt_tag[j]  = ent_tag[i];
        end
      end
      if (push_store && (surv_cnt == LVL_BIT'(j))) begin
        nxt_reg[j]  = bus.br_cond_reg;
        nxt_pred[j] = bus.br_cond_pred;
        nxt_pc[j]   = bus.br_fail_pc;
        nxt_id[j]   = bus.br_fail_id;
        nxt_tag[j]  = bus.br_fail_tag_map;
      end
    end
    nxt_cnt = bus.flush ? '0 : surv_cnt + {{(LVL_BIT-1){1'b0}}, push_store};
  end

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= nxt_cnt;
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < SPEC_DEPTH; j++) begin
      ent_reg[j]  <= nxt_reg[j];
      ent_pred[j] <= nxt_pred[j];
      ent_pc[j]   <= nxt_pc[j];
      ent_id[j]   <= nxt_id[j];
      ent_tag[j]  <= nxt_tag[j];
    end
  end
endmodule

// File: tb/tb_spec_tracker_mw.sv
// Scoreboard bench for spec_tracker_mw: a queue-based reference model predicts each
// cycle's resolution outputs, and a negedge monitor compares them against the DUT.
module tb_spec_tracker_mw;
  localparam int D = 4;
  localparam int L = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spec_tracker_mw_if bus_if ();
  spec_tracker_mw dut (.clk(clk), .rst(rst), .bus(bus_if));

  typedef struct { int r; int p; int pc; int id; int tag; } ent_t;
  typedef struct {
    int rdy; int cnt; int cur; bit cur_chk; int succ; int fvld;
    int flvl; bit flvl_chk; int fpc; int fid; int ftag;
    logic [L*(D+1)-1:0] lv; logic [D:0] lvm;
  } exp_t;

  ent_t q[$];
  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int errors = 0;
  int wv[2], wr[2], wval[2];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int port_val(input int r);
    for (int p = 0; p < 2; p++)
      if (wv[p] != 0 && wr[p] == r) return wval[p];
    return -1;
  endfunction

  // Reference: resolve by list filtering, then rebuild the queue for the next cycle.
  task automatic model_step(input int bv, input int br, input int bp, input int pc,
                            input int id, input int tag, input int fl);
    exp_t x;
    ent_t ns[$];
    ent_t ne;
    int fidx = -1;
    int v, bpv;
    bit acc;
    bit anywb = (wv[0] != 0) || (wv[1] != 0);
    x = '{default: 0};
    x.rdy = (q.size() < D);
    x.cnt = q.size();
    for (int i = 0; i < q.size(); i++) begin
      v = port_val(q[i].r);
      if (v >= 0 && v == q[i].p) x.succ = 1;
      if (v >= 0 && v != q[i].p && fidx < 0) fidx = i;
    end
    x.lv = '0;
    x.lvm = 1;
    for (int i = 0; i < q.size(); i++) begin
      if (port_val(q[i].r) < 0 && (fidx < 0 || i < fidx)) begin
        ns.push_back(q[i]);
        x.lv[(i+1)*L +: L] = L'(ns.size());
        x.lvm[i+1] = 1'b1;
      end
    end
    if (q.size() == 0 && !anywb) begin
      for (int k = 0; k <= D; k++) x.lv[k*L +: L] = L'(k);
      x.lvm = '1;
      x.flvl_chk = 1'b1;
    end
    x.cur = ns.size();
    x.cur_chk = (fl == 0);
    acc = (bv != 0) && (x.rdy != 0);
    bpv = acc ? port_val(br) : -1;
    if (fl != 0) begin
      x.succ = 0;
      ns.delete();
    end else if (fidx >= 0) begin
      x.fvld = 1; x.flvl = fidx + 1;
      x.fpc = q[fidx].pc; x.fid = q[fidx].id; x.ftag = q[fidx].tag;
    end else if (bpv >= 0 && bpv != bp) begin
      x.fvld = 1; x.flvl = ns.size() + 1;
      x.fpc = pc; x.fid = id; x.ftag = tag;
    end else if (acc && bpv < 0) begin
      ne = '{r: br, p: bp, pc: pc, id: id, tag: tag};
      ns.push_back(ne);
    end
    sb.push_back(x);
    q = ns;
  endtask

  task automatic cyc(input int bv, input int br, input int bp,
                     input int w0v, input int w0r, input int w0val,
                     input int w1v, input int w1r, input int w1val,
                     input int fl, input int rs);
    int pc, id, tag;
    @(posedge clk);
    #1;
    pc = $urandom_range(0, 15);
    id = $urandom_range(0, 255);
    tag = $urandom_range(0, 4095);
    wv[0] = w0v; wr[0] = w0r; wval[0] = w0val;
    wv[1] = w1v; wr[1] = w1r; wval[1] = w1val;
    rst = rs[0];
    bus_if.flush = fl[0];
    bus_if.br_vld = bv[0];
    bus_if.br_cond_reg = br[2:0];
    bus_if.br_cond_pred = bp[0];
    bus_if.br_fail_pc = pc[3:0];
    bus_if.br_fail_id = id[7:0];
    bus_if.br_fail_tag_map = tag[11:0];
    bus_if.wb_vld = {w1v[0], w0v[0]};
    bus_if.wb_reg = {w1r[2:0], w0r[2:0]};
    bus_if.wb_val = {w1val[0], w0val[0]};
    if (rs != 0) q.delete();
    else model_step(bv, br, bp, pc, id, tag, fl);
  endtask

  task automatic idle();                       cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic push(input int r, input int p); cyc(1, r, p, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic flush1();                     cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("br_rdy", int'(bus_if.br_rdy), e.rdy);
      chk("spec_cnt", int'(bus_if.spec_cnt), e.cnt);
      if (e.cur_chk) chk("cur_spec_level", int'(bus_if.cur_spec_level), e.cur);
      chk("succ_vld", int'(bus_if.succ_vld), e.succ);
      chk("fail_vld", int'(bus_if.fail_vld), e.fvld);
      if (e.fvld != 0) begin
        chk("fail_level", int'(bus_if.fail_level), e.flvl);
        chk("fail_pc", int'(bus_if.fail_pc), e.fpc);
        chk("fail_id", int'(bus_if.fail_id), e.fid);
        chk("fail_tag_map", int'(bus_if.fail_tag_map), e.ftag);
      end else if (e.flvl_chk) begin
        chk("fail_level_idle", int'(bus_if.fail_level), 0);
      end
      for (int k = 0; k <= D; k++)
        if (e.lvm[k]) chk("nxt_levels", int'(bus_if.nxt_levels[k*L +: L]), int'(e.lv[k*L +: L]));
    end
  end

  initial begin
    rst = 1'b1;
    bus_if.flush = 1'b0; bus_if.br_vld = 1'b0; bus_if.br_cond_reg = '0; bus_if.br_cond_pred = 1'b0;
    bus_if.br_fail_pc = '0; bus_if.br_fail_id = '0; bus_if.br_fail_tag_map = '0;
    bus_if.wb_vld = '0; bus_if.wb_reg = '0; bus_if.wb_val = '0;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    push(3, 1); push(5, 0); idle();
    push(6, 1);
    cyc(0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0); idle();
    flush1(); push(3, 1); push(5, 0); push(6, 1);
    cyc(0, 0, 0, 1, 5, 1, 1, 6, 0, 0, 0); idle();
    flush1(); push(3, 1); push(5, 0); push(6, 1); push(7, 0);
    cyc(1, 2, 0, 1, 3, 1, 0, 0, 0, 0, 0); idle();
    flush1(); push(1, 0);
    cyc(1, 2, 1, 1, 2, 0, 0, 0, 0, 0, 0); idle();
    flush1(); push(3, 1); push(5, 0); push(6, 1);
    cyc(0, 0, 0, 1, 3, 0, 0, 0, 0, 1, 0); idle();
    flush1(); push(2, 0); push(4, 1);
    cyc(1, 7, 1, 1, 5, 0, 0, 0, 0, 0, 0); idle();
    flush1(); push(3, 1); push(5, 1); push(4, 0);
    cyc(1, 6, 0, 1, 5, 1, 1, 3, 1, 0, 0); idle();
    push(1, 1); push(2, 0);
    cyc(1, 3, 1, 1, 4, 1, 0, 0, 0, 0, 1); idle();
    for (int n = 0; n < 3000; n++) begin
      int w0r = $urandom_range(0, 7);
      int w1r = ($urandom_range(0, 9) < 2) ? w0r : $urandom_range(0, 7);
      cyc(($urandom_range(0, 99) < 60) ? 1 : 0, $urandom_range(0, 7), $urandom_range(0, 1),
          ($urandom_range(0, 99) < 40) ? 1 : 0, w0r, $urandom_range(0, 1),
          ($urandom_range(0, 99) < 40) ? 1 : 0, w1r, $urandom_range(0, 1),
          ($urandom_range(0, 99) < 3) ? 1 : 0, ($urandom_range(0, 199) < 2) ? 1 : 0);
    end
    idle();
    @(posedge clk);
    @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
